mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: T-cycle / M-cycle sequencer with a single-port external
// memory bus. Each M-cycle has four T-cycles. A memory access is captured
// at the end of T1 and its strobe is held for T2. While bus_ready is low,
// T2 is stretched with wait states. A wait-state timeout forces T2 to
// complete and sets a sticky bus error flag.
module mem_bus_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  m_cycles_in,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] addr_in,
    input  logic [7:0]  wdata_in,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ready,
    output logic [1:0]  t_cycle,
    output logic [2:0]  m_cycle,
    output logic        m1t1,
    output logic        writeback,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [7:0]  rdata_out,
    output logic        stall,
    output logic        bus_err
);

    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

    // Normalise the decoder's M-cycle count: 0 means a single M-cycle,
    // and anything above 6 is limited to 6.
    function automatic logic [2:0] clamp_len(input logic [2:0] raw);
        logic [2:0] res;
        if (raw == 3'd0) begin
            res = 3'd1;
        end else if (raw > 3'd6) begin
            res = 3'd6;
        end else begin
            res = raw;
        end
        return res;
    endfunction

    logic [1:0]    t_q, t_d;
    logic [2:0]    m_q, m_d;
    logic [2:0]    len_q, len_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          active_q, active_d;
    logic          we_q, we_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          err_q, err_d;

    logic          in_t2_s;
    logic          timeout_s;
    logic          hold_s;

    // T2 wait-state decode: hold while the bus is not ready, unless the
    // wait budget is used up, in which case the T2 exit is forced.
    always_comb begin
        in_t2_s   = active_q && (t_q == 2'd1);
        timeout_s = in_t2_s && (wait_q == WAIT_LIM);
        hold_s    = in_t2_s && !bus_ready && !timeout_s;
    end

    // Next-state logic for the T/M sequencer and the bus access.
    always_comb begin
        t_d      = t_q;
        m_d      = m_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        active_d = active_q;
        we_d     = we_q;
        wait_d   = wait_q;
        err_d    = err_q;

        // The instruction length is taken once per instruction, at M1 T4.
        // The new value also decides this wrap.
        if ((t_q == 2'd3) && (m_q == 3'd0)) begin
            len_d = clamp_len(m_cycles_in);
        end else begin
            len_d = len_q;
        end

        case (t_q)
            2'd0: begin
                t_d      = 2'd1;
                active_d = mem_req;
                if (mem_req) begin
                    addr_d  = addr_in;
                    we_d    = mem_we;
                    wdata_d = wdata_in;
                end else begin
                    addr_d  = addr_q;
                    we_d    = we_q;
                    wdata_d = wdata_q;
                end
            end
            2'd1: begin
                if (hold_s) begin
                    t_d    = 2'd1;
                    wait_d = wait_q + CW'(1);
                end else begin
                    t_d      = 2'd2;
                    wait_d   = '0;
                    active_d = 1'b0;
                    if (active_q && !we_q) begin
                        rdata_d = bus_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    if (timeout_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
            end
            2'd2: begin
                t_d = 2'd3;
            end
            2'd3: begin
                t_d = 2'd0;
                if (m_q == (len_d - 3'd1)) begin
                    m_d = 3'd0;
                end else begin
                    m_d = m_q + 3'd1;
                end
            end
            default: begin
                t_d = 2'd0;
            end
        endcase
    end

    // State registers. Reset aborts any access and restarts at M1 T1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_q      <= 2'd0;
            m_q      <= 3'd0;
            len_q    <= 3'd1;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            active_q <= 1'b0;
            we_q     <= 1'b0;
            wait_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            t_q      <= t_d;
            m_q      <= m_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            active_q <= active_d;
            we_q     <= we_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
        end
    end

    // Strobes are pure decodes of the registered access state, so a reset
    // drops them at once. The access is active only during T2.
    assign t_cycle   = t_q;
    assign m_cycle   = m_q;
    assign m1t1      = (m_q == 3'd0) && (t_q == 2'd0);
    assign writeback = (t_q == 2'd3);
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign rdata_out = rdata_q;
    assign bus_rd    = active_q && !we_q;
    assign bus_wr    = active_q && we_q;
    assign stall     = hold_s;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl. The reference model describes
// instructions as nested M-cycle/T-cycle loops. It describes accesses as a
// T2 phase that lasts min(waits, WAIT_MAX)+1 clocks.
module tb_mem_bus_ctrl;

    localparam int WAIT_MAX = 15;

    logic        clk;
    logic        rst;
    logic [2:0]  m_cycles_in;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] addr_in;
    logic [7:0]  wdata_in;
    logic [7:0]  bus_rdata;
    logic        bus_ready;
    logic [1:0]  t_cycle;
    logic [2:0]  m_cycle;
    logic        m1t1;
    logic        writeback;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  rdata_out;
    logic        stall;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference-model state.
    int          cur_in;
    int          cur_le;
    int          m_exp;
    logic [15:0] addr_exp;
    logic [7:0]  wdata_exp;
    logic [7:0]  rdata_exp;
    logic        err_exp;

    mem_bus_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .m_cycles_in(m_cycles_in), .mem_req(mem_req),
        .mem_we(mem_we), .addr_in(addr_in), .wdata_in(wdata_in),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .t_cycle(t_cycle),
        .m_cycle(m_cycle), .m1t1(m1t1), .writeback(writeback),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .rdata_out(rdata_out), .stall(stall), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff_len(input int l);
        if (l == 0) return 1;
        else if (l > 6) return 6;
        else return l;
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        mem_req  = 1'($urandom_range(0, 1));
        mem_we   = 1'($urandom_range(0, 1));
        addr_in  = 16'($urandom);
        wdata_in = 8'($urandom);
    endtask

    // Reset and release at a negedge. On return the DUT sits at M1 T1 and
    // this cycle's inputs have not been driven yet.
    task automatic apply_reset(input int len_in);
        rst         = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        bus_ready   = 1'b1;
        cur_in      = len_in;
        cur_le      = eff_len(len_in);
        m_cycles_in = 3'(len_in);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        m_exp     = 0;
        addr_exp  = 16'h0000;
        wdata_exp = 8'h00;
        rdata_exp = 8'h00;
        err_exp   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_req = 1'b1; mem_we = 1'b0; addr_in = 16'h1234;
        wdata_in = 8'h55; bus_rdata = 8'hFF; bus_ready = 1'b0; m_cycles_in = 3'd3;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (t_cycle !== 2'd0) begin n_fail++; $display("FAIL rst_t got %0d exp 0", t_cycle); end
        n_checks++; if (m_cycle !== 3'd0) begin n_fail++; $display("FAIL rst_m got %0d exp 0", m_cycle); end
        n_checks++; if (m1t1 !== 1'b1) begin n_fail++; $display("FAIL rst_m1t1 got %b exp 1", m1t1); end
        n_checks++; if (writeback !== 1'b0) begin n_fail++; $display("FAIL rst_wb got %b exp 0", writeback); end
        n_checks++; if (bus_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr got %h exp 0000", bus_addr); end
        n_checks++; if (bus_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata got %h exp 00", bus_wdata); end
        n_checks++; if (rdata_out !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got %h exp 00", rdata_out); end
        n_checks++; if ({bus_rd, bus_wr} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b exp 00", {bus_rd, bus_wr}); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", stall); end
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", bus_err); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (t_cycle !== 2'd0) begin n_fail++; $display("FAIL rst_hold_t got %0d exp 0", t_cycle); end
    endtask

    // Free-running sequencing with no memory traffic. fixed_len >= 0 holds
    // m_cycles_in constant. A negative value picks a random length for each
    // instruction and drives garbage on every clock except the latch clock.
    task automatic test_cycle_seq(input int n_instr, input int fixed_len);
        int l;
        int le;
        bit first;
        apply_reset(fixed_len >= 0 ? fixed_len : 1);
        first = 1'b1;
        for (int i = 0; i < n_instr; i++) begin
            l  = (fixed_len >= 0) ? fixed_len : int'($urandom_range(0, 7));
            le = eff_len(l);
            for (int m = 0; m < le; m++) begin
                for (int t = 0; t < 4; t++) begin
                    if (!first) advance();
                    first   = 1'b0;
                    mem_req = 1'b0;
                    bus_ready = 1'($urandom_range(0, 1));
                    if (fixed_len >= 0 || (m == 0 && t == 3)) m_cycles_in = 3'(l);
                    else m_cycles_in = 3'($urandom_range(0, 7));
                    #1;
                    n_checks++; if (t_cycle !== 2'(t)) begin n_fail++; $display("FAIL seq_t i%0d got %0d exp %0d", i, t_cycle, t); end
                    n_checks++; if (m_cycle !== 3'(m)) begin n_fail++; $display("FAIL seq_m i%0d got %0d exp %0d", i, m_cycle, m); end
                    n_checks++; if (m1t1 !== (m == 0 && t == 0)) begin n_fail++; $display("FAIL seq_m1t1 got %b exp %b", m1t1, (m == 0 && t == 0)); end
                    n_checks++; if (writeback !== (t == 3)) begin n_fail++; $display("FAIL seq_wb got %b exp %b", writeback, (t == 3)); end
                    n_checks++; if ({bus_rd, bus_wr, stall} !== 3'b000) begin n_fail++; $display("FAIL seq_idle got %b exp 000", {bus_rd, bus_wr, stall}); end
                end
            end
        end
    endtask

    // One M-cycle. The caller has just advanced into T1. On return the bench
    // has advanced into the next T1.
    task automatic run_access(input bit req, input bit we, input logic [15:0] a,
                              input logic [7:0] wd, input logic [7:0] rd, input int waits);
        int h;
        mem_req = req; mem_we = we; addr_in = a; wdata_in = wd;
        bus_ready = 1'($urandom_range(0, 1)); m_cycles_in = 3'(cur_in);
        #1;
        n_checks++; if (t_cycle !== 2'd0) begin n_fail++; $display("FAIL acc_t1 got %0d exp 0", t_cycle); end
        n_checks++; if (m_cycle !== 3'(m_exp)) begin n_fail++; $display("FAIL acc_m got %0d exp %0d", m_cycle, m_exp); end
        n_checks++; if (m1t1 !== (m_exp == 0)) begin n_fail++; $display("FAIL acc_m1t1 got %b exp %b", m1t1, (m_exp == 0)); end
        n_checks++; if ({bus_rd, bus_wr, stall} !== 3'b000) begin n_fail++; $display("FAIL acc_t1_idle got %b exp 000", {bus_rd, bus_wr, stall}); end
        if (req) begin addr_exp = a; wdata_exp = wd; end
        h = !req ? 0 : (waits > WAIT_MAX ? WAIT_MAX : waits);
        for (int i = 0; i <= h; i++) begin
            advance();
            junk_inputs();
            bus_ready = req ? (i < waits ? 1'b0 : 1'b1) : 1'($urandom_range(0, 1));
            bus_rdata = (i == h) ? rd : 8'($urandom);
            #1;
            n_checks++; if (t_cycle !== 2'd1) begin n_fail++; $display("FAIL acc_t2 clk%0d got %0d exp 1", i, t_cycle); end
            n_checks++; if (stall !== (req && i < h)) begin n_fail++; $display("FAIL acc_stall clk%0d got %b exp %b", i, stall, (req && i < h)); end
            n_checks++; if (bus_rd !== (req && !we)) begin n_fail++; $display("FAIL acc_rd clk%0d got %b exp %b", i, bus_rd, (req && !we)); end
            n_checks++; if (bus_wr !== (req && we)) begin n_fail++; $display("FAIL acc_wr clk%0d got %b exp %b", i, bus_wr, (req && we)); end
            n_checks++; if (bus_addr !== addr_exp) begin n_fail++; $display("FAIL acc_addr got %h exp %h", bus_addr, addr_exp); end
            n_checks++; if (bus_wdata !== wdata_exp) begin n_fail++; $display("FAIL acc_wdata got %h exp %h", bus_wdata, wdata_exp); end
            n_checks++; if (rdata_out !== rdata_exp) begin n_fail++; $display("FAIL acc_rdata_hold got %h exp %h", rdata_out, rdata_exp); end
            n_checks++; if (bus_err !== err_exp) begin n_fail++; $display("FAIL acc_err_t2 got %b exp %b", bus_err, err_exp); end
        end
        if (req && !we) rdata_exp = rd;
        if (req && waits >= WAIT_MAX) err_exp = 1'b1;
        advance();
        junk_inputs(); bus_ready = 1'($urandom_range(0, 1));
        #1;
        n_checks++; if (t_cycle !== 2'd2) begin n_fail++; $display("FAIL acc_t3 got %0d exp 2", t_cycle); end
        n_checks++; if ({bus_rd, bus_wr, stall} !== 3'b000) begin n_fail++; $display("FAIL acc_t3_idle got %b exp 000", {bus_rd, bus_wr, stall}); end
        n_checks++; if (rdata_out !== rdata_exp) begin n_fail++; $display("FAIL acc_rdata got %h exp %h", rdata_out, rdata_exp); end
        n_checks++; if (bus_err !== err_exp) begin n_fail++; $display("FAIL acc_err got %b exp %b", bus_err, err_exp); end
        n_checks++; if (bus_addr !== addr_exp) begin n_fail++; $display("FAIL acc_addr_t3 got %h exp %h", bus_addr, addr_exp); end
        advance();
        junk_inputs();
        #1;
        n_checks++; if (t_cycle !== 2'd3) begin n_fail++; $display("FAIL acc_t4 got %0d exp 3", t_cycle); end
        n_checks++; if (writeback !== 1'b1) begin n_fail++; $display("FAIL acc_wb got %b exp 1", writeback); end
        m_exp = (m_exp + 1) % cur_le;
        advance();
    endtask

    task automatic test_read_directed();
        apply_reset(1);
        run_access(1'b1, 1'b0, 16'hC000, 8'($urandom), 8'hA5, 0);
    endtask

    task automatic test_write_waits();
        apply_reset(1);
        run_access(1'b1, 1'b1, 16'h8001, 8'h3C, 8'($urandom), 2);
    endtask

    task automatic test_random_access();
        apply_reset(1);
        for (int i = 0; i < 12; i++)
            run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                       8'($urandom), 8'($urandom), int'($urandom_range(0, 5)));
    endtask

    task automatic test_back_to_back();
        apply_reset(3);
        for (int i = 0; i < 9; i++)
            run_access(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                       8'($urandom), int'($urandom_range(0, 3)));
    endtask

    task automatic test_timeout();
        apply_reset(1);
        run_access(1'b1, 1'b0, 16'h4000, 8'h11, 8'h5A, 40);
        for (int i = 0; i < 3; i++)
            run_access(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                       8'($urandom), int'($urandom_range(0, 2)));
    endtask

    task automatic test_reset_mid_read();
        apply_reset(1);
        run_access(1'b1, 1'b0, 16'h2222, 8'h00, 8'hC3, 0);
        mem_req = 1'b1; mem_we = 1'b0; addr_in = 16'h9ABC; wdata_in = 8'h77;
        #1;
        advance();
        bus_ready = 1'b0;
        #1;
        n_checks++; if ({bus_rd, stall} !== 2'b11) begin n_fail++; $display("FAIL mid_wait got %b exp 11", {bus_rd, stall}); end
        advance();
        #2 rst = 1'b0;
        #1;
        n_checks++; if (bus_rd !== 1'b0) begin n_fail++; $display("FAIL mid_rd got %b exp 0", bus_rd); end
        n_checks++; if (t_cycle !== 2'd0) begin n_fail++; $display("FAIL mid_t got %0d exp 0", t_cycle); end
        n_checks++; if (m_cycle !== 3'd0) begin n_fail++; $display("FAIL mid_m got %0d exp 0", m_cycle); end
        n_checks++; if (rdata_out !== 8'h00) begin n_fail++; $display("FAIL mid_rdata got %h exp 00", rdata_out); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall got %b exp 0", stall); end
        n_checks++; if (bus_addr !== 16'h0000) begin n_fail++; $display("FAIL mid_addr got %h exp 0000", bus_addr); end
        @(negedge clk);
        rst = 1'b1; m_exp = 0; addr_exp = 16'h0000; wdata_exp = 8'h00;
        rdata_exp = 8'h00; err_exp = 1'b0;
        run_access(1'b1, 1'b0, 16'hBEEF, 8'h01, 8'h96, 1);
        run_access(1'b1, 1'b1, 16'h0F0F, 8'hE1, 8'h00, 0);
    endtask

    initial begin
        test_reset();
        test_cycle_seq(3, 1);
        test_cycle_seq(3, 3);
        test_cycle_seq(2, 0);
        test_cycle_seq(2, 7);
        test_cycle_seq(10, -1);
        test_read_directed();
        test_write_waits();
        test_random_access();
        test_back_to_back();
        test_timeout();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
